// File: rtl/event_arbiter.sv
// Round-robin arbiter for five one-cycle request sources with a per-grant holdoff window.
// Requests latch as pending bits; one event is offered at a time and accepted with evt_ready.
module event_arbiter #(
    parameter int unsigned HOLDOFF_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req_pulse,
    input  logic       evt_ready,
    input  logic       flush,
    output logic       evt_valid,
    output logic [2:0] evt_id,
    output logic [4:0] pending,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    localparam logic [25:0] HOLD_LOAD =
        (HOLDOFF_CYCLES == 0) ? 26'd0 : 26'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OFFER,
        S_HOLDOFF
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_pending;
    logic [4:0]  w_pending_nxt;
    logic [2:0]  r_last;
    logic [2:0]  r_evt_id;
    logic        r_evt_valid;
    logic        r_busy;
    logic [7:0]  r_drop_cnt;
    logic [7:0]  w_drop_nxt;
    logic [25:0] r_hold_cnt;
    logic [25:0] w_hold_nxt;
    logic        w_accept;
    logic        w_load_id;
    logic [2:0]  w_pick;
    logic [4:0]  w_clear;
    logic [4:0]  w_drop;
    logic [2:0]  w_drop_num;
    logic [8:0]  w_drop_sum;

    // Nearest pending index at or after last+1, wrapping modulo 5.
    function automatic logic [2:0] rr_pick(input logic [4:0] req, input logic [2:0] last);
        logic [2:0]  pick;
        int unsigned idx;
        pick = 3'd0;
        idx  = 0;
        for (int unsigned k = 5; k >= 1; k--) begin
            idx = (32'(last) + k) % 5;
            if (req[idx]) begin
                pick = 3'(idx);
            end
        end
        return pick;
    endfunction

    assign w_accept = (r_state == S_OFFER) && evt_ready;
    assign w_pick   = rr_pick(r_pending, r_last);
    assign w_clear  = w_accept ? (5'b00001 << r_evt_id) : 5'b00000;
    assign w_drop   = req_pulse & r_pending & ~w_clear;

    always_comb begin
        w_pending_nxt = (r_pending & ~w_clear) | req_pulse;
        if (flush) begin
            w_pending_nxt = '0;
        end
    end

    // Drops are counted even when flush discards the latch in the same cycle.
    always_comb begin
        w_drop_num = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            w_drop_num = w_drop_num + {2'b00, w_drop[i]};
        end
        w_drop_sum = {1'b0, r_drop_cnt} + {6'b000000, w_drop_num};
        w_drop_nxt = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_load_id   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flush && (r_pending != 5'b00000)) begin
                    w_state_nxt = S_OFFER;
                    w_load_id   = 1'b1;
                end
            end
            S_OFFER: begin
                if (w_accept) begin
                    w_state_nxt = (HOLDOFF_CYCLES == 0) ? S_IDLE : S_HOLDOFF;
                    w_hold_nxt  = HOLD_LOAD;
                end else if (flush) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLDOFF: begin
                if (r_hold_cnt == 26'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_hold_nxt = r_hold_cnt - 26'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_last      <= 3'd4;
            r_evt_id    <= '0;
            r_evt_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_drop_cnt  <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_drop_cnt  <= w_drop_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_evt_valid <= (w_state_nxt == S_OFFER);
            r_busy      <= (w_state_nxt != S_IDLE);
            if (w_load_id) begin
                r_evt_id <= w_pick;
            end
            if (w_accept) begin
                r_last <= r_evt_id;
            end
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign pending   = r_pending;
    assign busy      = r_busy;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_event_arbiter.sv
// Directed-vector bench for event_arbiter with HOLDOFF_CYCLES=4.
// Status vector layout: {evt_valid, evt_id[2:0], busy, pending[4:0]}.
module tb_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req_pulse;
    logic       evt_ready;
    logic       flush;
    logic       evt_valid;
    logic [2:0] evt_id;
    logic [4:0] pending;
    logic       busy;
    logic [7:0] drop_cnt;
    logic [9:0] st;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    event_arbiter #(.HOLDOFF_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_pulse (req_pulse),
        .evt_ready (evt_ready),
        .flush     (flush),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .pending   (pending),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    assign st = {evt_valid, evt_id, busy, pending};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; req_pulse = '0; flush = 1'b0; evt_ready = 1'b0;
        tick;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; req_pulse = '1; flush = 1'b1; evt_ready = 1'b1;
        tick;
        tick;
        total++;
        if (st !== 10'b0_000_0_00000) begin
            bad++; $display("FAIL reset_state: got %b want %b", st, 10'b0_000_0_00000);
        end
        total++;
        if (drop_cnt !== 8'd0) begin
            bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt);
        end
        rst = 1'b1; req_pulse = '0; flush = 1'b0; evt_ready = 1'b0;
        tick;
        total++;
        if (st !== 10'b0_000_0_00000) begin
            bad++; $display("FAIL reset_release: got %b want %b", st, 10'b0_000_0_00000);
        end
    endtask

    task automatic test_single_feed;
        do_reset;
        evt_ready = 1'b1; req_pulse = 5'b00100;
        tick;
        req_pulse = '0;
        total++;
        if (st !== 10'b0_000_0_00100) begin
            bad++; $display("FAIL feed_pend: got %b want %b", st, 10'b0_000_0_00100);
        end
        tick;
        total++;
        if (st !== 10'b1_010_1_00100) begin
            bad++; $display("FAIL feed_offer: got %b want %b", st, 10'b1_010_1_00100);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            total++;
            if (st !== 10'b0_010_1_00000) begin
                bad++; $display("FAIL feed_holdoff[%0d]: got %b want %b", i, st, 10'b0_010_1_00000);
            end
        end
        tick;
        total++;
        if (st !== 10'b0_010_0_00000) begin
            bad++; $display("FAIL feed_idle: got %b want %b", st, 10'b0_010_0_00000);
        end
    endtask

    task automatic test_all_five;
        logic [4:0] pend_exp;
        logic [9:0] exp;
        do_reset;
        evt_ready = 1'b1; req_pulse = 5'b11111;
        tick;
        req_pulse = '0;
        total++;
        if (st !== 10'b0_000_0_11111) begin
            bad++; $display("FAIL rr_pend: got %b want %b", st, 10'b0_000_0_11111);
        end
        pend_exp = 5'b11111;
        for (int k = 0; k < 5; k++) begin
            tick;
            exp = {1'b1, 3'(k), 1'b1, pend_exp};
            total++;
            if (st !== exp) begin
                bad++; $display("FAIL rr_offer[%0d]: got %b want %b", k, st, exp);
            end
            pend_exp[k] = 1'b0;
            for (int j = 0; j < 5; j++) begin
                tick;
                total++;
                if (evt_valid !== 1'b0) begin
                    bad++; $display("FAIL rr_gap[%0d.%0d]: got %b want 0", k, j, evt_valid);
                end
            end
        end
        total++;
        if (st !== 10'b0_100_0_00000) begin
            bad++; $display("FAIL rr_end: got %b want %b", st, 10'b0_100_0_00000);
        end
        total++;
        if (drop_cnt !== 8'd0) begin
            bad++; $display("FAIL rr_drop: got %0d want 0", drop_cnt);
        end
    endtask

    task automatic test_hold_stable;
        do_reset;
        evt_ready = 1'b0; req_pulse = 5'b01000;
        tick;
        req_pulse = '0;
        tick;
        total++;
        if (st !== 10'b1_011_1_01000) begin
            bad++; $display("FAIL hold_offer: got %b want %b", st, 10'b1_011_1_01000);
        end
        for (int c = 0; c < 10; c++) begin
            req_pulse = (c == 2 || c == 5) ? 5'b01000 : (c == 7) ? 5'b00010 : 5'b00000;
            tick;
            total++;
            if ({evt_valid, evt_id} !== 4'b1_011) begin
                bad++; $display("FAIL hold_id[%0d]: got %b want %b", c, {evt_valid, evt_id}, 4'b1_011);
            end
        end
        req_pulse = '0;
        total++;
        if (drop_cnt !== 8'd2) begin
            bad++; $display("FAIL hold_drop: got %0d want 2", drop_cnt);
        end
        total++;
        if (pending !== 5'b01010) begin
            bad++; $display("FAIL hold_pend: got %b want %b", pending, 5'b01010);
        end
        evt_ready = 1'b1;
        tick;
        total++;
        if (st !== 10'b0_011_1_00010) begin
            bad++; $display("FAIL hold_accept: got %b want %b", st, 10'b0_011_1_00010);
        end
        for (int i = 0; i < 5; i++) tick;
        total++;
        if (st !== 10'b1_001_1_00010) begin
            bad++; $display("FAIL hold_next: got %b want %b", st, 10'b1_001_1_00010);
        end
    endtask

    task automatic test_saturate;
        do_reset;
        evt_ready = 1'b0; req_pulse = 5'b00001;
        tick;
        for (int i = 1; i <= 300; i++) begin
            tick;
            if (i == 100) begin
                total++;
                if (drop_cnt !== 8'd100) begin
                    bad++; $display("FAIL sat_mid: got %0d want 100", drop_cnt);
                end
            end
        end
        req_pulse = '0;
        total++;
        if (drop_cnt !== 8'd255) begin
            bad++; $display("FAIL sat_full: got %0d want 255", drop_cnt);
        end
        total++;
        if (st !== 10'b1_000_1_00001) begin
            bad++; $display("FAIL sat_state: got %b want %b", st, 10'b1_000_1_00001);
        end
    endtask

    task automatic test_flush;
        flush = 1'b1; req_pulse = 5'b00100;
        tick;
        flush = 1'b0; req_pulse = '0;
        total++;
        if (st !== 10'b0_000_0_00000) begin
            bad++; $display("FAIL flush_offer: got %b want %b", st, 10'b0_000_0_00000);
        end
        total++;
        if (drop_cnt !== 8'd255) begin
            bad++; $display("FAIL flush_drop: got %0d want 255", drop_cnt);
        end
        tick;
        total++;
        if (st !== 10'b0_000_0_00000) begin
            bad++; $display("FAIL flush_idle: got %b want %b", st, 10'b0_000_0_00000);
        end
    endtask

    task automatic test_back_to_back;
        do_reset;
        evt_ready = 1'b1; req_pulse = 5'b00101;
        tick;
        req_pulse = '0;
        tick;
        total++;
        if (st !== 10'b1_000_1_00101) begin
            bad++; $display("FAIL b2b_offer0: got %b want %b", st, 10'b1_000_1_00101);
        end
        req_pulse = 5'b00001;
        tick;
        req_pulse = '0;
        total++;
        if (st !== 10'b0_000_1_00101) begin
            bad++; $display("FAIL b2b_setwins: got %b want %b", st, 10'b0_000_1_00101);
        end
        total++;
        if (drop_cnt !== 8'd0) begin
            bad++; $display("FAIL b2b_drop: got %0d want 0", drop_cnt);
        end
        for (int i = 0; i < 5; i++) tick;
        total++;
        if (st !== 10'b1_010_1_00101) begin
            bad++; $display("FAIL b2b_offer2: got %b want %b", st, 10'b1_010_1_00101);
        end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        total++;
        if (st !== 10'b0_010_1_00000) begin
            bad++; $display("FAIL b2b_flush_accept: got %b want %b", st, 10'b0_010_1_00000);
        end
        for (int i = 0; i < 4; i++) tick;
        total++;
        if (st !== 10'b0_010_0_00000) begin
            bad++; $display("FAIL b2b_idle: got %b want %b", st, 10'b0_010_0_00000);
        end
        req_pulse = 5'b01001;
        tick;
        req_pulse = '0;
        tick;
        total++;
        if (st !== 10'b1_011_1_01001) begin
            bad++; $display("FAIL b2b_rr_after_flush: got %b want %b", st, 10'b1_011_1_01001);
        end
    endtask

    task automatic test_reset_holdoff;
        do_reset;
        evt_ready = 1'b1; req_pulse = 5'b00001;
        tick;
        req_pulse = '0;
        tick;
        tick;
        req_pulse = 5'b01010;
        tick;
        req_pulse = '0;
        total++;
        if (st !== 10'b0_000_1_01010) begin
            bad++; $display("FAIL rsthold_pre: got %b want %b", st, 10'b0_000_1_01010);
        end
        rst = 1'b0; flush = 1'b1; req_pulse = 5'b11111;
        tick;
        total++;
        if (st !== 10'b0_000_0_00000) begin
            bad++; $display("FAIL rsthold_state: got %b want %b", st, 10'b0_000_0_00000);
        end
        total++;
        if (drop_cnt !== 8'd0) begin
            bad++; $display("FAIL rsthold_drop: got %0d want 0", drop_cnt);
        end
        rst = 1'b1; flush = 1'b0; req_pulse = 5'b01010;
        tick;
        req_pulse = '0;
        total++;
        if (st !== 10'b0_000_0_01010) begin
            bad++; $display("FAIL rsthold_pend: got %b want %b", st, 10'b0_000_0_01010);
        end
        tick;
        total++;
        if (st !== 10'b1_001_1_01010) begin
            bad++; $display("FAIL rsthold_grant: got %b want %b", st, 10'b1_001_1_01010);
        end
    endtask

    initial begin
        rst = 1'b0; req_pulse = '0; evt_ready = 1'b0; flush = 1'b0;
        test_reset;
        test_single_feed;
        test_all_five;
        test_hold_stable;
        test_saturate;
        test_flush;
        test_back_to_back;
        test_reset_holdoff;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
